// File: rtl/mips_mem_pkg.sv
// Shared types for the unified-memory port arbiter.
// Holds the arbiter FSM state encoding, the grant-owner encoding and the
// default data/address width.
package mips_mem_pkg;

  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_owner_e;

endpackage

// File: rtl/mem_timeout_counter.sv
// Up-counter with synchronous clear, enable and a registered terminal-count flag.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : force the count to 0 (wins over en_i)
//   en_i       : advance the count by one
//   tc_o       : high while the count equals TERMINAL-1
module mem_timeout_counter #(
  parameter int unsigned TERMINAL = 64,
  parameter int unsigned CNT_W    = (TERMINAL > 1) ? $clog2(TERMINAL) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TERMINAL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tc_q;

  // Next count; clear has priority over enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Flag is precomputed from the next count so it is registered yet aligned with cnt_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tc_q  <= (LAST == '0);
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= (cnt_d == LAST);
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch (IF)
// and data access (MEM). One transaction at a time; data has priority, with a
// starvation guard limiting consecutive data grants while a fetch waits.
// Ports:
//   clk, rst_n                        : clock, asynchronous active-low reset
//   if_req/if_addr -> if_ready/if_rdata : fetch handshake
//   d_req/d_we/d_addr/d_wdata -> d_ready/d_rdata : data handshake
//   m_en/m_we/m_addr/m_wdata, m_rdata/m_valid   : memory side
//   if_stall, d_stall                 : combinational pipeline stalls
//   bus_err                           : sticky timeout flag
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned MAX_D_BURST = 4,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              m_en,
  output logic              m_we,
  output logic [DATA_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_valid,
  output logic              if_stall,
  output logic              d_stall,
  output logic              bus_err
);

  localparam int unsigned BURST_W = $clog2(MAX_D_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_D_BURST);

  arb_state_e         state_q;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic               m_en_q, m_we_q;
  logic [DATA_W-1:0]  m_addr_q, m_wdata_q;
  logic [DATA_W-1:0]  if_rdata_q, d_rdata_q;
  logic               if_ready_q, d_ready_q, bus_err_q;

  logic               gnt_valid;
  gnt_owner_e         gnt_owner;
  logic               busy;
  logic               tmo_tc;

  assign busy = (state_q != IDLE);

  // Timeout counter: held at zero in IDLE, counts every BUSY cycle.
  mem_timeout_counter #(
    .TERMINAL (TIMEOUT)
  ) u_tmo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (~busy),
    .en_i  (busy),
    .tc_o  (tmo_tc)
  );

  // Arbitration. The IDLE cycle carrying a ready pulse is a bubble: the
  // requester still holds req for the finished transaction, so no grant is made.
  always_comb begin
    gnt_valid   = 1'b0;
    gnt_owner   = GNT_IF;
    burst_cnt_d = burst_cnt_q;
    if ((state_q == IDLE) && !if_ready_q && !d_ready_q) begin
      if (d_req && !(if_req && (burst_cnt_q == BURST_MAX))) begin
        gnt_valid = 1'b1;
        gnt_owner = GNT_D;
        if (if_req) begin
          if (burst_cnt_q != BURST_MAX) begin
            burst_cnt_d = burst_cnt_q + BURST_W'(1);
          end
        end else begin
          burst_cnt_d = '0;
        end
      end else if (if_req) begin
        gnt_valid   = 1'b1;
        gnt_owner   = GNT_IF;
        burst_cnt_d = '0;
      end
    end
  end

  // Transaction FSM with registered memory strobes and completion pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      m_en_q      <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      m_en_q      <= 1'b0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      burst_cnt_q <= burst_cnt_d;
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            m_en_q <= 1'b1;
            if (gnt_owner == GNT_D) begin
              state_q   <= BUSY_D;
              m_we_q    <= d_we;
              m_addr_q  <= d_addr;
              m_wdata_q <= d_wdata;
            end else begin
              state_q   <= BUSY_IF;
              m_we_q    <= 1'b0;
              m_addr_q  <= if_addr;
              m_wdata_q <= '0;
            end
          end
        end
        BUSY_IF: begin
          // m_valid wins over a coincident timeout.
          if (m_valid || tmo_tc) begin
            state_q    <= IDLE;
            if_ready_q <= 1'b1;
            if_rdata_q <= m_valid ? m_rdata : '0;
            if (!m_valid) begin
              bus_err_q <= 1'b1;
            end
          end
        end
        BUSY_D: begin
          if (m_valid || tmo_tc) begin
            state_q   <= IDLE;
            d_ready_q <= 1'b1;
            d_rdata_q <= (m_valid && !m_we_q) ? m_rdata : '0;
            if (!m_valid) begin
              bus_err_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_en     = m_en_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign if_rdata = if_rdata_q;
  assign if_ready = if_ready_q;
  assign d_rdata  = d_rdata_q;
  assign d_ready  = d_ready_q;
  assign bus_err  = bus_err_q;

  assign if_stall = if_req & ~if_ready_q;
  assign d_stall  = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Inputs change #1 after a rising edge; outputs are sampled at the same point.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  import mips_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        m_en;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_valid;
  logic        if_stall;
  logic        d_stall;
  logic        bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic        mem_auto;
  logic        pend;
  logic [31:0] pend_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .DATA_W      (32),
    .MAX_D_BURST (4),
    .TIMEOUT     (64)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ready  (d_ready),
    .m_en     (m_en),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .m_valid  (m_valid),
    .if_stall (if_stall),
    .d_stall  (d_stall),
    .bus_err  (bus_err)
  );

  // Memory contents seen by the bench's responder.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0000_0010) ? 32'h2008_0005 : (32'h1000_0000 | a);
  endfunction

  // Advance one cycle; when mem_auto is set, answer each m_en one cycle later.
  task automatic step();
    @(posedge clk);
    #1;
    if (mem_auto) begin
      m_valid = pend;
      m_rdata = pend ? mem_word(pend_addr) : 32'h0;
    end
    pend      = mem_auto && m_en;
    pend_addr = m_addr;
  endtask

  task automatic test_reset();
    int          en_cnt;
    int          en_cyc;
    int          rdy_cnt;
    int          rdy_cyc;
    logic [31:0] en_addr;
    logic        en_we;
    logic [31:0] rd;
    en_cnt = 0; en_cyc = -1; rdy_cnt = 0; rdy_cyc = -1;
    en_addr = 32'hx; en_we = 1'bx; rd = 32'hx;
    rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    m_valid = 1'b0; m_rdata = 32'h0; mem_auto = 1'b1; pend = 1'b0; pend_addr = 32'h0;
    repeat (2) step();
    n_checks++;
    if ({m_en, m_we, if_ready, d_ready, bus_err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000", {m_en, m_we, if_ready, d_ready, bus_err});
    end
    n_checks++;
    if ({m_addr, m_wdata, if_rdata, d_rdata} !== 128'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {m_addr, m_wdata, if_rdata, d_rdata});
    end
    n_checks++;
    if (dut.state_q !== IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (m_en) begin en_cnt++; en_cyc = i; en_addr = m_addr; en_we = m_we; end
      if (if_ready) begin rdy_cnt++; rdy_cyc = i; rd = if_rdata; if_req = 1'b0; end
    end
    n_checks++;
    if (en_cnt !== 1 || en_cyc !== 1) begin
      n_fail++; $display("FAIL reset_men: got %0d pulses at %0d expected 1 at 1", en_cnt, en_cyc);
    end
    n_checks++;
    if (en_addr !== 32'h10 || en_we !== 1'b0) begin
      n_fail++; $display("FAIL reset_maddr: got %h we=%b expected 00000010 we=0", en_addr, en_we);
    end
    n_checks++;
    if (rdy_cnt !== 1 || rdy_cyc !== 3) begin
      n_fail++; $display("FAIL reset_ifready: got %0d pulses at %0d expected 1 at 3", rdy_cnt, rdy_cyc);
    end
    n_checks++;
    if (rd !== 32'h2008_0005) begin
      n_fail++; $display("FAIL reset_ifrdata: got %h expected 20080005", rd);
    end
  endtask

  task automatic test_simultaneous();
    int          n_en;
    int          en2_cyc;
    int          d_rdy_cyc;
    int          if_rdy_cyc;
    int          stall_bad;
    logic [31:0] a1, w1, a2, w2, d_rd, if_rd;
    logic        we1, we2, dst1, dst_rdy;
    n_en = 0; en2_cyc = -1; d_rdy_cyc = -1; if_rdy_cyc = -1; stall_bad = 0;
    a1 = 'x; w1 = 'x; a2 = 'x; w2 = 'x; d_rd = 'x; if_rd = 'x;
    we1 = 1'bx; we2 = 1'bx; dst1 = 1'bx; dst_rdy = 1'bx;
    if_req = 1'b1; if_addr = 32'h14;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 1) dst1 = d_stall;
      if (m_en) begin
        if (n_en == 0) begin a1 = m_addr; we1 = m_we; w1 = m_wdata; end
        else if (n_en == 1) begin a2 = m_addr; we2 = m_we; w2 = m_wdata; en2_cyc = i; end
        n_en++;
      end
      if (d_ready) begin d_rdy_cyc = i; d_rd = d_rdata; dst_rdy = d_stall; d_req = 1'b0; d_we = 1'b0; end
      if (if_ready) begin if_rdy_cyc = i; if_rd = if_rdata; if_req = 1'b0; end
      else if (if_rdy_cyc < 0 && if_stall !== 1'b1) stall_bad++;
    end
    n_checks++;
    if (a1 !== 32'h40 || we1 !== 1'b1 || w1 !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL sim_first_data: got a=%h we=%b w=%h expected a=00000040 we=1 w=deadbeef", a1, we1, w1);
    end
    n_checks++;
    if (d_rdy_cyc !== 3 || d_rd !== 32'h0) begin
      n_fail++; $display("FAIL sim_dready: got cyc %0d rdata %h expected cyc 3 rdata 0", d_rdy_cyc, d_rd);
    end
    n_checks++;
    if (dst1 !== 1'b1 || dst_rdy !== 1'b0) begin
      n_fail++; $display("FAIL sim_dstall: got %b/%b expected 1/0", dst1, dst_rdy);
    end
    n_checks++;
    if (en2_cyc !== 5 || a2 !== 32'h14 || we2 !== 1'b0 || w2 !== 32'h0) begin
      n_fail++; $display("FAIL sim_fetch_issue: got cyc %0d a=%h we=%b w=%h expected cyc 5 a=00000014 we=0 w=0", en2_cyc, a2, we2, w2);
    end
    n_checks++;
    if (if_rdy_cyc !== 7 || if_rd !== 32'h1000_0014) begin
      n_fail++; $display("FAIL sim_ifready: got cyc %0d rdata %h expected cyc 7 rdata 10000014", if_rdy_cyc, if_rd);
    end
    n_checks++;
    if (stall_bad !== 0) begin
      n_fail++; $display("FAIL sim_ifstall: got %0d cycles without stall expected 0", stall_bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] log_q[$];
    logic [31:0] exp_log [7];
    logic [31:0] got;
    int          nd;
    int          b_at4;
    int          b_at_f;
    exp_log = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h100, 32'h210, 32'h214};
    nd = 0; b_at4 = -1; b_at_f = -1;
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_wdata = 32'h0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (m_en) begin
        log_q.push_back(m_addr);
        if (m_addr == 32'h20C) b_at4 = int'(dut.burst_cnt_q);
        if (m_addr == 32'h100) b_at_f = int'(dut.burst_cnt_q);
      end
      if (d_ready) begin
        n_checks++;
        if (d_rdata !== (32'h1000_0000 | d_addr)) begin
          n_fail++; $display("FAIL b2b_drdata: got %h expected %h", d_rdata, 32'h1000_0000 | d_addr);
        end
        nd++;
        d_addr = d_addr + 32'h4;
        if (nd == 6) d_req = 1'b0;
      end
      if (if_ready) if_req = 1'b0;
    end
    n_checks++;
    if (log_q.size() !== 7) begin
      n_fail++; $display("FAIL b2b_grant_count: got %0d expected 7", log_q.size());
    end
    for (int k = 0; k < 7; k++) begin
      got = (k < log_q.size()) ? log_q[k] : 32'hx;
      n_checks++;
      if (got !== exp_log[k]) begin
        n_fail++; $display("FAIL b2b_grant_order[%0d]: got %h expected %h", k, got, exp_log[k]);
      end
    end
    n_checks++;
    if (b_at4 !== 4 || b_at_f !== 0) begin
      n_fail++; $display("FAIL b2b_burst_cnt: got %0d/%0d expected 4/0", b_at4, b_at_f);
    end
  endtask

  task automatic test_timeout();
    int          rdy_cyc;
    int          err_early;
    int          late_rdy;
    int          if_cyc;
    logic [31:0] rd, if_rd;
    logic        err_at;
    rdy_cyc = -1; err_early = 0; late_rdy = 0; if_cyc = -1;
    rd = 'x; if_rd = 'x; err_at = 1'bx;
    mem_auto = 1'b0; pend = 1'b0; m_valid = 1'b0; m_rdata = 32'hBAD0_0000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    for (int i = 1; i <= 70; i++) begin
      step();
      if (d_ready && rdy_cyc < 0) begin rdy_cyc = i; rd = d_rdata; err_at = bus_err; d_req = 1'b0; end
      if (rdy_cyc < 0 && bus_err) err_early++;
    end
    n_checks++;
    if (rdy_cyc !== 65 || rd !== 32'h0) begin
      n_fail++; $display("FAIL tmo_dready: got cyc %0d rdata %h expected cyc 65 rdata 0", rdy_cyc, rd);
    end
    n_checks++;
    if (err_at !== 1'b1 || err_early !== 0) begin
      n_fail++; $display("FAIL tmo_buserr: got %b early=%0d expected 1 early=0", err_at, err_early);
    end
    m_valid = 1'b1; m_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      step();
      if (d_ready || if_ready) late_rdy++;
    end
    m_valid = 1'b0;
    n_checks++;
    if (late_rdy !== 0) begin
      n_fail++; $display("FAIL tmo_late_valid: got %0d ready pulses expected 0", late_rdy);
    end
    mem_auto = 1'b1; pend = 1'b0;
    if_req = 1'b1; if_addr = 32'h20;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (if_ready) begin if_cyc = i; if_rd = if_rdata; if_req = 1'b0; end
    end
    n_checks++;
    if (if_cyc !== 3 || if_rd !== 32'h1000_0020) begin
      n_fail++; $display("FAIL tmo_next_fetch: got cyc %0d rdata %h expected cyc 3 rdata 10000020", if_cyc, if_rd);
    end
    n_checks++;
    if (bus_err !== 1'b1) begin
      n_fail++; $display("FAIL tmo_sticky: got %b expected 1", bus_err);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    mem_auto = 1'b0; pend = 1'b0; m_valid = 1'b0;
    if_req = 1'b1; if_addr = 32'h24;
    step();
    n_checks++;
    if (m_en !== 1'b1 || m_addr !== 32'h24) begin
      n_fail++; $display("FAIL rstmid_issue: got m_en=%b addr %h expected 1 00000024", m_en, m_addr);
    end
    step();
    rst_n = 1'b0; if_req = 1'b0;
    #1;
    n_checks++;
    if ({m_en, m_we, if_ready, d_ready, bus_err, if_stall, d_stall} !== 7'b0 ||
        {m_addr, m_wdata, if_rdata, d_rdata} !== 128'h0) begin
      n_fail++; $display("FAIL rstmid_outputs: got flags %b data %h expected all 0",
                         {m_en, m_we, if_ready, d_ready, bus_err, if_stall, d_stall},
                         {m_addr, m_wdata, if_rdata, d_rdata});
    end
    step();
    rst_n = 1'b1; m_valid = 1'b1; m_rdata = 32'h0000_0055;
    for (int i = 0; i < 4; i++) begin
      step();
      if (if_ready || d_ready || m_en) bad++;
    end
    m_valid = 1'b0;
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL rstmid_late_valid: got %0d active cycles expected 0", bad);
    end
    n_checks++;
    if (dut.state_q !== IDLE) begin
      n_fail++; $display("FAIL rstmid_state: got %0d expected %0d", dut.state_q, IDLE);
    end
  endtask

  task automatic test_idle_stray();
    int          bad;
    int          d_cyc;
    logic [31:0] wd;
    bad = 0; d_cyc = -1; wd = 'x;
    mem_auto = 1'b0; pend = 1'b0;
    m_valid = 1'b1; m_rdata = 32'hFFFF_0000;
    for (int i = 0; i < 3; i++) begin
      step();
      if (if_ready || d_ready || m_en || dut.state_q != IDLE) bad++;
    end
    m_valid = 1'b0;
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL idle_stray: got %0d active cycles expected 0", bad);
    end
    mem_auto = 1'b1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h0BAD_F00D;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (m_en) wd = m_wdata;
      if (d_ready) begin d_cyc = i; d_req = 1'b0; d_we = 1'b0; end
    end
    n_checks++;
    if (d_cyc !== 3 || wd !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL idle_then_write: got cyc %0d wdata %h expected cyc 3 wdata 0badf00d", d_cyc, wd);
    end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_idle_stray();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
